// File: rtl/pipe_seq.sv
// Pipeline sequencer: turns hazard-controller stall/mispredict requests into
// PC / IF/ID / ID/EX controls, with saturating statistics and a stall watchdog.
module pipe_seq #(
  parameter int STALL_LIMIT = 12,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCStall,
  input  logic             MP,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [1:0]       SeqState,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount,
  output logic             Deadlock
);

  localparam int WD_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          state, state_next;
  logic            stall_hit;   // cycle counted as stalled
  logic            mp_flush;    // IF/ID flush caused by a mispredict
  logic [WD_W-1:0] wd_cnt;

  // NOTE: every output is defaulted before the case so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    stall_hit  = 1'b0;
    mp_flush   = 1'b0;
    case (state)
      INIT: begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IFIDFlush  = 1'b1;
        IDEXBubble = 1'b1;
        state_next = RUN;
      end
      default: begin
        // RUN, STALL and FLUSH share one decode; FLUSH masks PCStall because
        // the hazard compare was made against a squashed instruction.
        if (MP) begin
          IFIDFlush  = 1'b1;
          IDEXBubble = 1'b1;
          mp_flush   = 1'b1;
          state_next = FLUSH;
        end else if (PCStall && state != FLUSH) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          stall_hit  = 1'b1;
          state_next = STALL;
        end else begin
          state_next = RUN;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT;
      StallCycles <= '0;
      FlushCount  <= '0;
      wd_cnt      <= '0;
      Deadlock    <= 1'b0;
    end else begin
      state <= state_next;
      if (stall_hit && StallCycles != {CNT_W{1'b1}})
        StallCycles <= StallCycles + 1'b1;
      if (mp_flush && FlushCount != {CNT_W{1'b1}})
        FlushCount <= FlushCount + 1'b1;
      if (!stall_hit)
        wd_cnt <= '0;
      else if (wd_cnt != WD_W'(STALL_LIMIT))
        wd_cnt <= wd_cnt + 1'b1;
      if (stall_hit && wd_cnt == WD_W'(STALL_LIMIT - 1))
        Deadlock <= 1'b1;
    end
  end

  assign SeqState = state;

endmodule

// File: tb/tb_pipe_seq.sv
// Scoreboard bench for pipe_seq: a driver pushes the expected per-cycle response
// from a behavioural model, a monitor pops and compares at the falling edge.
module tb_pipe_seq;

  localparam int LIMIT = 12;

  logic        clock = 1'b0;
  logic        reset, PCStall, MP;
  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Deadlock;
  logic [1:0]  SeqState;
  logic [15:0] StallCycles, FlushCount;
  logic        s_PCWrite, s_IFIDWrite, s_IFIDFlush, s_IDEXBubble, s_Deadlock;
  logic [1:0]  s_SeqState;
  logic [3:0]  s_StallCycles, s_FlushCount;

  pipe_seq #(.STALL_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .PCStall(PCStall), .MP(MP),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .SeqState(SeqState), .StallCycles(StallCycles),
    .FlushCount(FlushCount), .Deadlock(Deadlock)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation checks.
  pipe_seq #(.STALL_LIMIT(LIMIT), .CNT_W(4)) dut_small (
    .clock(clock), .reset(reset), .PCStall(PCStall), .MP(MP),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IFIDFlush(s_IFIDFlush),
    .IDEXBubble(s_IDEXBubble), .SeqState(s_SeqState), .StallCycles(s_StallCycles),
    .FlushCount(s_FlushCount), .Deadlock(s_Deadlock)
  );

  always #5 clock = ~clock;

  typedef struct {
    int pcw, ifw, flush, bubble, state, stalls, flushes, dead;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: state as a plain integer, raw unbounded event totals.
  int   m_known = 0;
  int   m_state, m_stall_tot, m_flush_tot, m_run, m_dead;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // One clock cycle: apply inputs, predict this cycle's response, advance model.
  task automatic cycle(input bit rst, input bit st, input bit mp);
    exp_t e;
    int   nxt, is_stall, is_mpf;
    reset = rst; PCStall = st; MP = mp;
    is_stall = 0; is_mpf = 0;
    if (m_known != 0) begin
      if (m_state == 0) begin
        e.pcw = 0; e.ifw = 0; e.flush = 1; e.bubble = 1; nxt = 1;
      end else if (mp) begin
        e.pcw = 1; e.ifw = 1; e.flush = 1; e.bubble = 1; nxt = 3; is_mpf = 1;
      end else if (st && m_state != 3) begin
        e.pcw = 0; e.ifw = 0; e.flush = 0; e.bubble = 1; nxt = 2; is_stall = 1;
      end else begin
        e.pcw = 1; e.ifw = 1; e.flush = 0; e.bubble = 0; nxt = 1;
      end
      e.state = m_state; e.stalls = m_stall_tot; e.flushes = m_flush_tot; e.dead = m_dead;
      q.push_back(e);
    end else begin
      nxt = 0;
    end
    if (rst) begin
      m_known = 1; m_state = 0; m_stall_tot = 0; m_flush_tot = 0; m_run = 0; m_dead = 0;
    end else if (m_known != 0) begin
      m_state     = nxt;
      m_stall_tot = m_stall_tot + is_stall;
      m_flush_tot = m_flush_tot + is_mpf;
      m_run       = is_stall ? ((m_run + 1 > LIMIT) ? LIMIT : m_run + 1) : 0;
      if (m_run == LIMIT) m_dead = 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic repeat_cycle(input int n, input bit rst, input bit st, input bit mp);
    for (int i = 0; i < n; i++) cycle(rst, st, mp);
  endtask

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("PCWrite",        int'(PCWrite),       e.pcw);
        check("IFIDWrite",      int'(IFIDWrite),     e.ifw);
        check("IFIDFlush",      int'(IFIDFlush),     e.flush);
        check("IDEXBubble",     int'(IDEXBubble),    e.bubble);
        check("SeqState",       int'(SeqState),      e.state);
        check("StallCycles",    int'(StallCycles),   sat(e.stalls, 16));
        check("FlushCount",     int'(FlushCount),    sat(e.flushes, 16));
        check("Deadlock",       int'(Deadlock),      e.dead);
        check("StallCycles_w4", int'(s_StallCycles), sat(e.stalls, 4));
        check("FlushCount_w4",  int'(s_FlushCount),  sat(e.flushes, 4));
        check("PCWrite_w4",     int'(s_PCWrite),     e.pcw);
      end
    end
  end

  initial begin
    reset = 1'b1; PCStall = 1'b0; MP = 1'b0;
    @(posedge clock);
    #1;
    // Reset held with both requests active, then release into INIT -> RUN.
    repeat_cycle(3, 1, 1, 1);
    repeat_cycle(3, 0, 0, 0);
    // Three-cycle stall, then a single mispredict pulse.
    repeat_cycle(3, 0, 1, 0);
    repeat_cycle(2, 0, 0, 0);
    cycle(0, 0, 1);
    repeat_cycle(2, 0, 0, 0);
    // Mispredict and stall together while stalled; stall masked in FLUSH.
    repeat_cycle(2, 0, 1, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    repeat_cycle(2, 0, 0, 0);
    // Back-to-back mispredicts keep FLUSH and count each one.
    repeat_cycle(3, 0, 0, 1);
    repeat_cycle(2, 0, 0, 0);
    // Watchdog: 11 stalls must not trip it, 12 must, and it stays sticky.
    repeat_cycle(11, 0, 1, 0);
    repeat_cycle(2, 0, 0, 0);
    repeat_cycle(12, 0, 1, 0);
    repeat_cycle(4, 0, 0, 0);
    // Long stall drives the narrow counters into saturation.
    repeat_cycle(20, 0, 1, 0);
    repeat_cycle(2, 0, 0, 0);
    // Reset in the middle of a stall and of a flush.
    repeat_cycle(3, 0, 1, 0);
    cycle(1, 1, 0);
    repeat_cycle(2, 0, 0, 0);
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    repeat_cycle(2, 0, 0, 0);
    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 12));
    repeat_cycle(2, 0, 0, 0);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
